// File: rtl/mtp_pkg.sv
// Shared types and constants for the instruction fetch stage.
package mtp_pkg;

   localparam int DWIDTH = 32;
   localparam int AWIDTH = 16;

   // Decoder treats opcode[18:15]=4'b1111 as a no-op; driven whenever nothing valid is presented.
   localparam logic [DWIDTH-1:0] NOP_INSTR = 32'h0007_8000;

   typedef enum logic {FETCH, DROP} fetch_state_t;

   typedef struct packed {
      logic [AWIDTH-1:0] pc;
      logic [DWIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries. Flush wins over push/pop in the same cycle.
module fetch_fifo
   import mtp_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  fetch_entry_t           data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output fetch_entry_t           head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o,
   output logic                   full_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   // Pointers carry one extra wrap bit so count is a plain subtraction.
   logic [PW:0]  wr_q, rd_q;
   fetch_entry_t mem_q [DEPTH];

   // Pointer update; flush empties the FIFO regardless of push/pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i)  rd_q <= rd_q + 1'b1;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q[PW-1:0]] <= data_i;
   end

   assign count_o = wr_q - rd_q;
   assign empty_o = (count_o == '0);
   assign full_o  = (count_o == DEPTH_C);
   assign head_o  = mem_q[rd_q[PW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding memory requests,
// buffers words in a prefetch FIFO and presents them to the decoder.
// Word and address widths come from mtp_pkg (DWIDTH=32, AWIDTH=16).
module instr_fetch_unit
   import mtp_pkg::*;
#(
   parameter int                DEPTH    = 2,
   parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [AWIDTH-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DWIDTH-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [AWIDTH-1:0] redirect_pc,
   input  logic              dec_ready,
   output logic              instr_valid,
   output logic [DWIDTH-1:0] instr_out,
   output logic [AWIDTH-1:0] instr_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_t      state_q, state_d;
   logic [AWIDTH-1:0] pc_q, pc_d;
   logic [AWIDTH-1:0] drop_addr_q, drop_addr_d;
   logic              out_q, out_d;
   logic              started_q;

   fetch_entry_t      fifo_head;
   logic [CW-1:0]     fifo_count;
   logic              fifo_empty, fifo_full;
   logic              push, pop, issue;

   // A new request may only start when a FIFO slot is free for it, counting the one in flight.
   assign issue     = (state_q == FETCH) && started_q && !out_q && (fifo_count < DEPTH_C);
   assign imem_req  = (state_q == DROP) || out_q || issue;
   assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

   assign pop       = instr_valid && dec_ready && !redirect;

   // Next-state: PC advance on accepted words, redirect handling and the DROP shadow request.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      out_d       = out_q;
      push        = 1'b0;
      case (state_q)
         FETCH: begin
            if (redirect) begin
               pc_d = redirect_pc;
               if (imem_req && !imem_ack) begin
                  // Memory still owes us a word at the old address; hold the request and bin it.
                  state_d     = DROP;
                  drop_addr_d = pc_q;
                  out_d       = 1'b1;
               end else begin
                  out_d = 1'b0;
               end
            end else if (imem_req && imem_ack) begin
               push  = !fifo_full;
               pc_d  = pc_q + 1'b1;
               out_d = 1'b0;
            end else if (imem_req) begin
               out_d = 1'b1;
            end
         end
         DROP: begin
            if (redirect) pc_d = redirect_pc;
            if (imem_ack) begin
               state_d = FETCH;
               out_d   = 1'b0;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   // State, PC and outstanding-request registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         drop_addr_q <= RESET_PC;
         out_q       <= 1'b0;
         started_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
         out_q       <= out_d;
         started_q   <= 1'b1;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  ('{pc: pc_q, instr: imem_rdata}),
      .pop_i   (pop),
      .flush_i (redirect),
      .head_o  (fifo_head),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign instr_valid = !fifo_empty;
   assign instr_out   = instr_valid ? fifo_head.instr : NOP_INSTR;
   assign instr_pc    = instr_valid ? fifo_head.pc    : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory model with programmable ack latency,
// a stream-level reference model checked every cycle, and directed literal checks.
module tb_instr_fetch_unit;
   import mtp_pkg::*;

   localparam int DEPTH = 2;

   logic        clk, rst;
   logic        imem_req, imem_ack, redirect, dec_ready, instr_valid;
   logic [15:0] imem_addr, redirect_pc, instr_pc;
   logic [31:0] imem_rdata, instr_out;

   int unsigned lat;
   int unsigned wcnt;
   int n_chk = 0, n_err = 0, n_ack = 0, n_acc = 0;

   instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .dec_ready   (dec_ready),
      .instr_valid (instr_valid),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: mem[i] = i, acks once req has been held for lat cycles (lat=0: same cycle).
   always @(posedge clk or posedge rst) begin
      if (rst)                        wcnt <= 0;
      else if (!imem_req || imem_ack) wcnt <= 0;
      else                            wcnt <= wcnt + 1;
   end
   assign imem_ack   = imem_req && (wcnt >= lat);
   assign imem_rdata = {16'h0000, imem_addr};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: the decoder stream is consecutive PCs from the last restart point,
   // the buffer never holds more than DEPTH words, and a request hit by redirect is discarded.
   int          m_occ;
   logic [15:0] m_exp, m_next, p_addr;
   bit          m_drop, m_out, m_started, p_req, p_ack, m_acc;

   always @(negedge clk) begin
      if (rst) begin
         m_occ = 0; m_exp = 16'h0; m_next = 16'h0;
         m_drop = 0; m_out = 0; m_started = 0; p_req = 0; p_ack = 0; p_addr = 16'h0;
      end else begin
         chk("valid", instr_valid, m_occ > 0);
         if (m_occ > 0) begin
            chk("instr_pc", instr_pc, m_exp);
            chk("instr_out", instr_out, {16'h0, m_exp});
         end else begin
            chk("nop_out", instr_out, NOP_INSTR);
            chk("nop_pc", instr_pc, 0);
         end
         chk("req", imem_req, m_drop || (m_started && (m_out || m_occ < DEPTH)));
         if (imem_req && !m_drop) chk("addr", imem_addr, m_next);
         if (imem_req && p_req && !p_ack) chk("addr_stable", imem_addr, p_addr);

         m_acc = (m_occ > 0) && dec_ready;
         if (imem_req && imem_ack) n_ack++;
         if (m_acc) n_acc++;

         if (redirect) begin
            m_occ = 0; m_exp = redirect_pc; m_next = redirect_pc;
            m_drop = imem_req && !imem_ack;
            m_out  = m_drop;
         end else begin
            if (imem_req && imem_ack) begin
               if (m_drop) m_drop = 0;
               else begin m_occ++; m_next++; end
               m_out = 0;
            end else if (imem_req) begin
               m_out = 1;
            end
            if (m_acc) begin m_occ--; m_exp++; end
         end
         m_started = 1;
         p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      end
   end

   int a;

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; dec_ready = 1'b1; lat = 0;
      step(2);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr_out, 32'h0007_8000);
      chk("rst_pc", instr_pc, 0);

      // Zero-wait streaming
      rst = 1'b0;
      step(1); chk("t1_req1", imem_req, 1); chk("t1_val1", instr_valid, 0);
      step(1); chk("t1_val2", instr_valid, 1); chk("t1_pc0", instr_pc, 0);
      step(1); chk("t1_pc1", instr_pc, 1); chk("t1_instr1", instr_out, 1);
      step(1); chk("t1_pc2", instr_pc, 2);
      step(8);

      // Decoder stalled: exactly DEPTH words fetched
      rst = 1'b1; dec_ready = 1'b0; step(2); a = n_ack; rst = 1'b0;
      step(10);
      chk("t2_acks", n_ack - a, 2);
      chk("t2_req", imem_req, 0);
      chk("t2_valid", instr_valid, 1);
      chk("t2_instr", instr_out, 0);
      chk("t2_pc", instr_pc, 0);
      dec_ready = 1'b1; step(4);

      // 3-cycle memory: one instruction every 4 cycles
      rst = 1'b1; lat = 3; step(2); rst = 1'b0;
      step(12); a = n_acc; step(20);
      chk("t3_rate", n_acc - a, 5);

      // Redirect while a request to 0x0005 is pending
      rst = 1'b1; lat = 2; step(2); rst = 1'b0;
      a = 0;
      for (int i = 0; i < 60 && a == 0; i++) begin
         step(1);
         if (imem_req && imem_addr == 16'h0005) a = 1;
      end
      chk("t4_reach5", a, 1);
      redirect = 1'b1; redirect_pc = 16'h0040; step(1); redirect = 1'b0;
      chk("t4_hold_req", imem_req, 1);
      chk("t4_hold_addr", imem_addr, 16'h0005);
      chk("t4_flushed", instr_valid, 0);
      step(2);
      chk("t4_new_req", imem_req, 1);
      chk("t4_new_addr", imem_addr, 16'h0040);
      step(3);
      chk("t4_first_valid", instr_valid, 1);
      chk("t4_first_pc", instr_pc, 16'h0040);

      // Redirect coinciding with ack and pop
      lat = 0; step(4);
      chk("t5_pre", instr_valid && imem_ack, 1);
      redirect = 1'b1; redirect_pc = 16'h0020; step(1); redirect = 1'b0;
      chk("t5_valid", instr_valid, 0);
      chk("t5_nop", instr_out, 32'h0007_8000);
      chk("t5_pc", instr_pc, 0);
      step(1);
      chk("t5_restart", instr_pc, 16'h0020);

      // PC wrap
      redirect = 1'b1; redirect_pc = 16'hFFFE; step(1); redirect = 1'b0;
      chk("t6_addr_fffe", imem_addr, 16'hFFFE);
      step(1); chk("t6_addr_ffff", imem_addr, 16'hFFFF);
      step(1); chk("t6_addr_0000", imem_addr, 16'h0000);
      chk("t6_pc_ffff", instr_pc, 16'hFFFF);

      // Reset mid-request
      lat = 3; step(2);
      chk("t6_pending", imem_req && !imem_ack, 1);
      rst = 1'b1; #1;
      chk("t6_rst_req", imem_req, 0);
      chk("t6_rst_valid", instr_valid, 0);
      step(2); rst = 1'b0; step(5);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
